// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, converter scheduler states and limits.
package fpu_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rm_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } fcvt_state_t;

    localparam int FCVT_MAX_LAT = 40;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanning from a registered
// pointer; the pointer moves past the winner when the grant is taken.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    logic [PW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]   rot;
    logic [N-1:0]   rot_oh;
    logic [2*N-1:0] grant_dbl;

    // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot       = N'({req, req} >> ptr_q);
        rot_oh    = rot & (~rot + N'(1));
        grant_dbl = {{N{1'b0}}, rot_oh} << ptr_q;
        grant     = grant_dbl[N-1:0] | grant_dbl[2*N-1:N];
    end

    // NOTE: next-state logic assigns its default first, so no path leaves ptr_d unassigned (no latch).
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            for (int k = 0; k < N; k++) begin
                if (grant[k]) ptr_d = (k == N - 1) ? '0 : PW'(k + 1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fcvt_sched.sv
// Shares one multi-cycle int->float converter among NUM_REQ requesters, with a
// round-robin grant, a one-cycle hold before release and a watchdog abort.
module fcvt_sched
    import fpu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int TAG_W   = 5,
    parameter  int TIMEOUT = 48,
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int WD_W    = $clog2(TIMEOUT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*32-1:0]    req_a,
    input  logic [NUM_REQ*3-1:0]     req_rm,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [31:0]              conv_a,
    output logic [2:0]               conv_rm,
    output logic                     conv_hold,
    input  logic                     conv_stb,
    input  logic [31:0]              conv_z,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_z,
    output logic [TAG_W-1:0]         resp_tag,
    output logic [ID_W-1:0]          resp_id,
    output logic                     resp_err,
    output logic                     busy
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_HOLD = HOLD;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]         state_q, state_d;
    logic [31:0]        a_q, a_d;
    rm_t                rm_q, rm_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               hold_q, hold_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [31:0]        z_q, z_d;
    logic               err_q, err_d;
    logic [NUM_REQ-1:0] grant;
    logic               fire;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (fire),
        .grant   (grant)
    );

    assign fire      = (state_q == ST_IDLE) && (|grant);
    assign req_ready = (state_q == ST_IDLE) ? grant : '0;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        rm_d    = rm_q;
        tag_d   = tag_q;
        id_d    = id_q;
        hold_d  = hold_q;
        wdog_d  = wdog_q;
        z_d     = z_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (grant[k]) begin
                            a_d   = req_a[k*32 +: 32];
                            rm_d  = rm_t'(req_rm[k*3 +: 3]);
                            tag_d = req_tag[k*TAG_W +: TAG_W];
                            id_d  = ID_W'(k);
                        end
                    end
                    state_d = ST_HOLD;
                end
            end
            // conv_a has been stable for a full cycle before the converter leaves reset.
            ST_HOLD: begin
                hold_d  = 1'b0;
                wdog_d  = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                wdog_d = wdog_q + 1'b1;
                if (conv_stb) begin
                    z_d     = conv_z;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                    state_d = ST_RESP;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    z_d     = '0;
                    err_d   = 1'b1;
                    hold_d  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            rm_q    <= RNE;
            tag_q   <= '0;
            id_q    <= '0;
            hold_q  <= 1'b1;
            wdog_q  <= '0;
            z_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            rm_q    <= rm_d;
            tag_q   <= tag_d;
            id_q    <= id_d;
            hold_q  <= hold_d;
            wdog_q  <= wdog_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign conv_a     = a_q;
    assign conv_rm    = rm_q;
    assign conv_hold  = hold_q;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_z     = z_q;
    assign resp_tag   = tag_q;
    assign resp_id    = id_q;
    assign resp_err   = err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fcvt_sched.sv
// Self-checking bench for fcvt_sched: transaction-level reference model, a
// converter model with configurable latency, directed cases and random traffic.
module tb_fcvt_sched;

    localparam int N       = 2;
    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 48;
    localparam int IW      = $clog2(N);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N-1:0]           req_valid = '0;
    logic [N-1:0]           req_ready;
    logic [N*32-1:0]        req_a = '0;
    logic [N*3-1:0]         req_rm = '0;
    logic [N*TAG_W-1:0]     req_tag = '0;
    logic [31:0]            conv_a;
    logic [2:0]             conv_rm;
    logic                   conv_hold;
    logic                   conv_stb = 1'b0;
    logic [31:0]            conv_z = '0;
    logic                   resp_valid;
    logic                   resp_ready = 1'b1;
    logic [31:0]            resp_z;
    logic [TAG_W-1:0]       resp_tag;
    logic [IW-1:0]          resp_id;
    logic                   resp_err;
    logic                   busy;

    fcvt_sched #(.NUM_REQ(N), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_rm(req_rm), .req_tag(req_tag),
        .conv_a(conv_a), .conv_rm(conv_rm), .conv_hold(conv_hold),
        .conv_stb(conv_stb), .conv_z(conv_z),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_z(resp_z), .resp_tag(resp_tag), .resp_id(resp_id),
        .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Unsigned 32-bit integer to IEEE single with the requested rounding mode.
    function automatic logic [31:0] u2f(input logic [31:0] a, input logic [2:0] rm);
        int e, sh;
        logic [31:0] m, rem, half;
        logic up;
        if (a == 0) return 32'h0;
        e = 31;
        while (!a[e]) e--;
        if (e <= 23) begin
            m = a << (23 - e);
        end else begin
            sh   = e - 23;
            m    = a >> sh;
            rem  = a & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            case (rm)
                3'd0:    up = (rem > half) || (rem == half && m[0]);
                3'd3:    up = (rem != 0);
                3'd4:    up = (rem >= half);
                default: up = 1'b0;
            endcase
            if (up) m = m + 32'd1;
            if (m[24]) begin
                m = m >> 1;
                e++;
            end
        end
        return {1'b0, 8'(e + 127), m[22:0]};
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // ---------------- shared state (each variable has exactly one writer) ----
    int         lat_of [N];          // driver: converter latency per pending request
    bit         keep [N];            // driver: hold valid after a grant
    int         seen [N];            // driver
    bit         rand_mode = 1'b0;    // driver
    bit         stray_en = 1'b0;     // driver
    bit         hang_flag = 1'b0;    // driver
    logic [31:0] lit_z [16];         // driver: hand-computed responses
    logic [31:0] lit_tag [16];
    logic [31:0] lit_id [16];
    logic [31:0] lit_err [16];
    int         lit_n = 0;

    int         exp_lat = 0;         // compare: latency of the in-flight request
    int         grant_cnt [N];       // compare
    int         grant_total = 0;     // compare
    int         n_checks = 0;        // compare
    int         n_fail = 0;          // compare
    int         run_cnt = 0;         // converter model

    // ---------------- converter model ----------------------------------------
    always @(posedge clk) begin
        #1;
        if (conv_hold) run_cnt = 0;
        else           run_cnt++;
        if (!conv_hold && run_cnt == exp_lat) begin
            conv_stb = 1'b1;
            conv_z   = u2f(conv_a, conv_rm);
        end else if (conv_hold && stray_en && ($urandom % 3 == 0)) begin
            conv_stb = 1'b1;
            conv_z   = $urandom;
        end else begin
            conv_stb = 1'b0;
            conv_z   = $urandom;
        end
    end

    // ---------------- compare process with reference model -------------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    bit          outstanding = 1'b0;
    bit          pinned = 1'b0;
    int          cyc = 0;
    int          m_ptr = 0;
    int          lit_idx = 0;
    logic [31:0] o_a;
    logic [2:0]  o_rm;
    logic [31:0] o_tag;
    int          o_id;
    int          o_lat;

    always @(negedge clk) begin
        int          w, eff;
        logic [N-1:0] er;
        bit          in_run, exp_rv;
        logic [31:0] exp_z;
        if (!pinned) begin
            check("model_u2f_one",  u2f(32'd1, 3'd0),          32'h3F800000);
            check("model_u2f_16",   u2f(32'h10, 3'd0),         32'h41800000);
            check("model_u2f_max",  u2f(32'hFFFFFFFF, 3'd0),   32'h4F800000);
            check("model_u2f_rtz",  u2f(32'hFFFFFFFF, 3'd1),   32'h4F7FFFFF);
            pinned = 1'b1;
        end
        check("tb_timeout", 32'(hang_flag), 32'd0);
        if (rst) begin
            check("rst_busy",       32'(busy), 32'd0);
            check("rst_conv_hold",  32'(conv_hold), 32'd1);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
            check("rst_req_ready",  32'(req_ready), 32'd0);
            check("rst_resp_z",     resp_z, 32'd0);
            check("rst_resp_tag",   32'(resp_tag), 32'd0);
            check("rst_resp_id",    32'(resp_id), 32'd0);
            check("rst_resp_err",   32'(resp_err), 32'd0);
            check("rst_conv_a",     conv_a, 32'd0);
            check("rst_conv_rm",    32'(conv_rm), 32'd0);
            outstanding = 1'b0;
            m_ptr       = 0;
        end else begin
            w  = outstanding ? -1 : pick(req_valid, m_ptr);
            er = '0;
            if (w >= 0) er[w] = 1'b1;
            eff    = (o_lat < TIMEOUT) ? o_lat : TIMEOUT;
            in_run = outstanding && cyc >= 2 && cyc <= eff + 1;
            exp_rv = outstanding && cyc >= eff + 2;
            check("req_ready",  32'(req_ready), 32'(er));
            check("busy",       32'(busy), 32'(outstanding));
            check("conv_hold",  32'(conv_hold), 32'(!in_run));
            check("resp_valid", 32'(resp_valid), 32'(exp_rv));
            if (in_run) begin
                check("conv_a",  conv_a, o_a);
                check("conv_rm", 32'(conv_rm), 32'(o_rm));
            end
            if (exp_rv) begin
                exp_z = (o_lat > TIMEOUT) ? 32'd0 : u2f(o_a, o_rm);
                check("resp_z",   resp_z, exp_z);
                check("resp_tag", 32'(resp_tag), o_tag);
                check("resp_id",  32'(resp_id), 32'(o_id));
                check("resp_err", 32'(resp_err), 32'(o_lat > TIMEOUT));
            end
            if (outstanding) begin
                if (exp_rv && resp_ready) begin
                    outstanding = 1'b0;
                    if (lit_idx < lit_n) begin
                        check("lit_z",   resp_z, lit_z[lit_idx]);
                        check("lit_tag", 32'(resp_tag), lit_tag[lit_idx]);
                        check("lit_id",  32'(resp_id), lit_id[lit_idx]);
                        check("lit_err", 32'(resp_err), lit_err[lit_idx]);
                        lit_idx++;
                    end
                end else begin
                    cyc++;
                end
            end else if (w >= 0) begin
                o_a         = req_a[w*32 +: 32];
                o_rm        = req_rm[w*3 +: 3];
                o_tag       = 32'(req_tag[w*TAG_W +: TAG_W]);
                o_id        = w;
                o_lat       = lat_of[w];
                exp_lat     = lat_of[w];
                outstanding = 1'b1;
                cyc         = 1;
                m_ptr       = (w + 1) % N;
                grant_cnt[w]++;
                grant_total++;
            end
        end
    end

    // ---------------- driver -------------------------------------------------
    function automatic int rand_lat();
        int r;
        r = int'($urandom % 8);
        if (r == 0) return TIMEOUT + int'($urandom % 2);
        if (r == 1) return TIMEOUT - 1;
        if (r == 2) return 1000;
        return 4 + int'($urandom % 32);
    endfunction

    task automatic new_req(input int i, input logic [31:0] a, input logic [2:0] rm,
                           input logic [TAG_W-1:0] tag, input int lat);
        req_valid[i]             = 1'b1;
        req_a[i*32 +: 32]        = a;
        req_rm[i*3 +: 3]         = rm;
        req_tag[i*TAG_W +: TAG_W] = tag;
        lat_of[i]                = lat;
    endtask

    task automatic add_lit(input logic [31:0] z, input int tag, input int id, input int err);
        lit_z[lit_n]   = z;
        lit_tag[lit_n] = 32'(tag);
        lit_id[lit_n]  = 32'(id);
        lit_err[lit_n] = 32'(err);
        lit_n++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (grant_cnt[i] != seen[i]) begin
                seen[i] = grant_cnt[i];
                if (!keep[i]) req_valid[i] = 1'b0;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 3 == 0))
                    new_req(i, $urandom, 3'($urandom % 5), TAG_W'($urandom), rand_lat());
            end
            resp_ready = ($urandom % 4) != 0;
            stray_en   = ($urandom % 2) != 0;
        end
    endtask

    task automatic wait_idle(input int bound);
        for (int c = 0; c < bound; c++) begin
            if (req_valid == '0 && !busy && !resp_valid) return;
            step();
        end
        hang_flag = 1'b1;
    endtask

    initial begin
        int g0;
        bit got;
        for (int i = 0; i < N; i++) begin
            lat_of[i] = 10;
            keep[i]   = 1'b0;
            seen[i]   = 0;
        end
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single request from requester 0.
        add_lit(32'h3F800000, 3, 0, 0);
        new_req(0, 32'd1, 3'd0, 5'd3, 8);
        wait_idle(500);

        // Reset while the converter is running; stray strobes afterwards.
        new_req(0, 32'd123, 3'd1, 5'd7, 30);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            step();
            got = busy && !conv_hold;
        end
        if (!got) hang_flag = 1'b1;
        repeat (5) step();
        rst      = 1'b1;
        stray_en = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (6) step();
        stray_en = 1'b0;

        // Both requesters hold valid: grants alternate starting from 0.
        add_lit(32'h41800000, 1, 0, 0);
        add_lit(32'h4F800000, 2, 1, 0);
        add_lit(32'h41800000, 1, 0, 0);
        add_lit(32'h4F800000, 2, 1, 0);
        g0      = grant_total;
        keep[0] = 1'b1;
        keep[1] = 1'b1;
        new_req(0, 32'h10, 3'd0, 5'd1, 6);
        new_req(1, 32'hFFFFFFFF, 3'd0, 5'd2, 9);
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            step();
            got = (grant_total >= g0 + 4);
        end
        if (!got) hang_flag = 1'b1;
        keep[0]   = 1'b0;
        keep[1]   = 1'b0;
        req_valid = '0;
        wait_idle(500);

        // Backpressure in RESP while another request waits.
        add_lit(32'h43800000, 9, 1, 0);
        add_lit(32'h40A00000, 4, 0, 0);
        resp_ready = 1'b0;
        new_req(1, 32'h100, 3'd0, 5'd9, 12);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            step();
            got = resp_valid;
        end
        if (!got) hang_flag = 1'b1;
        new_req(0, 32'd5, 3'd3, 5'd4, 6);
        repeat (10) step();
        resp_ready = 1'b1;
        wait_idle(500);

        // Converter never strobes: watchdog abort, then a normal request.
        add_lit(32'h0, 11, 1, 1);
        new_req(1, 32'd42, 3'd0, 5'd11, 1000);
        wait_idle(500);
        add_lit(32'h40000000, 12, 1, 0);
        new_req(1, 32'd2, 3'd0, 5'd12, 5);
        wait_idle(500);

        // Zero operand with strobe landing on the timeout cycle.
        add_lit(32'h0, 13, 0, 0);
        new_req(0, 32'd0, 3'd0, 5'd13, TIMEOUT);
        wait_idle(500);

        // Random traffic with backpressure and stray strobes.
        g0        = grant_total;
        rand_mode = 1'b1;
        got       = 1'b0;
        for (int c = 0; c < 15000 && !got; c++) begin
            step();
            got = (grant_total >= g0 + 40);
        end
        if (!got) hang_flag = 1'b1;
        rand_mode  = 1'b0;
        resp_ready = 1'b1;
        stray_en   = 1'b0;
        wait_idle(2000);
        if (lit_idx != lit_n) hang_flag = 1'b1;

        repeat (3) step();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
